hv_efuse_load_ctrl: RTL and testbench
=====================================

HV_EFUSE_LOAD_CTRL -- requirements
Module: hv_efuse_load_ctrl

Interface
REQ-001 The module SHALL have parameter EFUSE_WORD_NUM, default 8, meaning the number of efuse words loaded per request (range 2..16).
REQ-002 The module SHALL have parameter EFUSE_DATA_W, default 8, meaning the efuse word width in bits.
REQ-003 The module SHALL have parameter EFUSE_ADDR_W, default 4, meaning the address width, with 2**EFUSE_ADDR_W >= EFUSE_WORD_NUM.
REQ-004 The module SHALL have parameters TSU_CYC (default 2), STRB_CYC (default 4) and THD_CYC (default 2), meaning the setup, strobe and hold phase lengths in clocks, each 1..15.
REQ-005 The module SHALL have these ports: i_clk  in  1  clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_efuse_load_req  in  1  level load request from the mode FSM.
REQ-008 i_efuse_ctrl_reg_en  in  1  load permitted; dropping it aborts the load.
REQ-009 o_efuse_load_done  out  1  one-cycle pulse when a load completes.
REQ-010 o_efuse_busy  out  1  high in any state other than IDLE.
REQ-011 o_efuse_csb  out  1  macro chip select, active-low.
REQ-012 o_efuse_strobe  out  1  macro read strobe, active-high.
REQ-013 o_efuse_addr  out  EFUSE_ADDR_W  macro word address.
REQ-014 i_efuse_rdata  in  EFUSE_DATA_W  macro read data.
REQ-015 o_reg_wen  out  1  register write pulse.
REQ-016 o_reg_waddr  out  EFUSE_ADDR_W  register word index.
REQ-017 o_reg_wdata  out  EFUSE_DATA_W  register write data.
REQ-018 o_efuse_csum_err  out  1  checksum mismatch flag.

Function
REQ-019 Start SHALL be a rising edge of i_efuse_load_req, detected against a registered copy, while in IDLE with i_efuse_ctrl_reg_en=1; a request that stays high SHALL NOT restart a load.
REQ-020 The FSM SHALL have states IDLE, SETUP, STRB, HOLD and DONE, with transitions IDLE->SETUP->STRB->HOLD, then HOLD->SETUP when words remain or HOLD->DONE after the last word, and DONE->IDLE unconditionally.
REQ-021 Each phase SHALL last exactly its parameter count in cycles, timed by one shared down-counter that is reloaded on every state entry.
REQ-022 o_efuse_csb SHALL be 0 in SETUP, STRB and HOLD and 1 otherwise.
REQ-023 o_efuse_strobe SHALL be 1 only in STRB.
REQ-024 o_efuse_addr SHALL equal the word index during SETUP, STRB and HOLD and 0 otherwise.
REQ-025 i_efuse_rdata SHALL be captured on the last STRB cycle.
REQ-026 o_reg_wen SHALL pulse for exactly one cycle, on the first HOLD cycle, with o_reg_waddr = word index and o_reg_wdata = the captured data.
REQ-027 The word index SHALL increment at HOLD exit and SHALL cover 0..EFUSE_WORD_NUM-1 with no wrap past the last word.
REQ-028 o_efuse_load_done SHALL be 1 only in DONE, which is exactly 1 + EFUSE_WORD_NUM*(TSU_CYC+STRB_CYC+THD_CYC) cycles after the first cycle the request is sampled high; with the defaults this is 65 cycles.
REQ-029 If i_efuse_ctrl_reg_en=0 in any non-IDLE state, the FSM SHALL go to IDLE on the next edge with no done pulse and no further writes; words already written SHALL stay written.
REQ-030 A request edge arriving while busy SHALL be ignored.
REQ-031 If a request edge and i_efuse_ctrl_reg_en=0 coincide, no load SHALL start.

Reset
REQ-032 While i_rst_n=0 the module SHALL asynchronously hold state=IDLE, o_efuse_csb=1, o_efuse_strobe=0, and o_efuse_addr, o_reg_wen, o_reg_waddr, o_reg_wdata, o_efuse_load_done, o_efuse_busy, o_efuse_csum_err and all counters at 0.
REQ-033 Reset asserted mid-load SHALL abandon the load; after release the module SHALL wait for a fresh request edge.

Configuration
REQ-034 The macro HV_EFUSE_CSUM_EN SHALL control checksumming: when defined, words 0..EFUSE_WORD_NUM-2 are XOR-accumulated and compared with the last word in DONE, o_efuse_csum_err is set on mismatch, cleared at the next load start, and held otherwise.
REQ-035 When HV_EFUSE_CSUM_EN is undefined, o_efuse_csum_err SHALL be constant 0 and no accumulator logic SHALL exist.
REQ-036 In both configurations all words, including the checksum word, SHALL be written to the registers.

Structure
REQ-037 The FSM state typedef (EFUSE_ST_W, with IDLE=0) and the default timing constants SHALL live in the shared hv package and parameter include.
REQ-038 The XOR accumulator SHALL be sub-module hv_efuse_csum, instantiated only under HV_EFUSE_CSUM_EN; the timing FSM SHALL remain in hv_efuse_load_ctrl.

Verification
REQ-039 Defaults, rdata = 8'h10+addr, one request edge -> 8 writes with addr 0..7 and data 8'h10..8'h17, each strobe exactly 4 cycles, and done exactly 65 cycles after request.
REQ-040 Request held high for 200 cycles -> exactly one done pulse; a second rising edge -> a second full load.
REQ-041 i_efuse_ctrl_reg_en dropped in word 3 STRB -> IDLE next cycle, only words 0..2 written, no done, csb=1.
REQ-042 Reset asserted during word 5 HOLD -> all outputs at reset values immediately; no activity after release until a new request edge.
REQ-043 With HV_EFUSE_CSUM_EN, words 01,02,04,08,10,20,40 and last word 7F -> csum_err=0; last word 7E -> csum_err=1 at done, cleared at the next start.
REQ-044 Without HV_EFUSE_CSUM_EN, the same stimulus -> csum_err stays 0 and all 8 words are still written.

Source files
------------

// File: rtl/hv_efuse_load_ctrl_pkg.sv
// Shared types and default timing constants for the efuse load controller.
// The optional checksum feature is enabled by defining HV_EFUSE_CSUM_EN.
package hv_efuse_load_ctrl_pkg;

  localparam int EFUSE_ST_W  = 3;
  localparam int EFUSE_CNT_W = 4;

  localparam int EFUSE_WORD_NUM_DEF = 8;
  localparam int EFUSE_DATA_W_DEF   = 8;
  localparam int EFUSE_ADDR_W_DEF   = 4;
  localparam int TSU_CYC_DEF        = 2;
  localparam int STRB_CYC_DEF       = 4;
  localparam int THD_CYC_DEF        = 2;

  typedef enum logic [EFUSE_ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_STRB  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } efuse_st_e;

  // True while the macro is selected (a word access is in flight).
  function automatic logic st_is_active(input efuse_st_e st);
    return (st == ST_SETUP) || (st == ST_STRB) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/hv_efuse_load_ctrl_if.sv
// Efuse macro access bus and shadow-register write bus.
// master: load controller side, slave: macro/register-file side.
interface hv_efuse_load_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              efuse_csb;
  logic              efuse_strobe;
  logic [ADDR_W-1:0] efuse_addr;
  logic [DATA_W-1:0] efuse_rdata;
  logic              reg_wen;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    output efuse_csb, efuse_strobe, efuse_addr, reg_wen, reg_waddr, reg_wdata,
    input  efuse_rdata
  );

  modport slave (
    input  efuse_csb, efuse_strobe, efuse_addr, reg_wen, reg_waddr, reg_wdata,
    output efuse_rdata
  );
endinterface

// File: rtl/hv_efuse_load_ctrl_csum.sv
// XOR accumulator over the payload words; compares against the final
// (checksum) word when the load completes. Only built with HV_EFUSE_CSUM_EN.
module hv_efuse_csum #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_acc_en,
  input  logic [DATA_W-1:0] i_acc_data,
  input  logic              i_chk,
  input  logic [DATA_W-1:0] i_chk_data,
  output logic              o_err
);

  logic [DATA_W-1:0] acc_r;
  logic              err_r;

  // Accumulate payload words; latch the mismatch result, clear on a new load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r <= {DATA_W{1'b0}};
      err_r <= 1'b0;
    end else if (i_clr) begin
      acc_r <= {DATA_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (i_acc_en) begin
        acc_r <= acc_r ^ i_acc_data;
      end
      if (i_chk) begin
        err_r <= (acc_r != i_chk_data);
      end
    end
  end

  assign o_err = err_r;

endmodule

// File: rtl/hv_efuse_load_ctrl.sv
// Efuse load controller: on a request edge, reads EFUSE_WORD_NUM words from
// the efuse macro with setup/strobe/hold timing and writes them to the shadow
// registers. Optional checksum check enabled by the macro HV_EFUSE_CSUM_EN.
module hv_efuse_load_ctrl
  import hv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_WORD_NUM = EFUSE_WORD_NUM_DEF,
  parameter int EFUSE_DATA_W   = EFUSE_DATA_W_DEF,
  parameter int EFUSE_ADDR_W   = EFUSE_ADDR_W_DEF,
  parameter int TSU_CYC        = TSU_CYC_DEF,
  parameter int STRB_CYC       = STRB_CYC_DEF,
  parameter int THD_CYC        = THD_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_efuse_load_req,
  input  logic i_efuse_ctrl_reg_en,
  output logic o_efuse_load_done,
  output logic o_efuse_busy,
  output logic o_efuse_csum_err,
  hv_efuse_load_ctrl_if.master efuse_bus
);

  localparam logic [EFUSE_CNT_W-1:0]  CNT_ZERO = {EFUSE_CNT_W{1'b0}};
  localparam logic [EFUSE_CNT_W-1:0]  TSU_LD   = EFUSE_CNT_W'(TSU_CYC - 1);
  localparam logic [EFUSE_CNT_W-1:0]  STRB_LD  = EFUSE_CNT_W'(STRB_CYC - 1);
  localparam logic [EFUSE_CNT_W-1:0]  THD_LD   = EFUSE_CNT_W'(THD_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] IDX_ZERO = {EFUSE_ADDR_W{1'b0}};
  localparam logic [EFUSE_ADDR_W-1:0] IDX_ONE  = EFUSE_ADDR_W'(1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  efuse_st_e               state_r, nxt_state_s;
  logic [EFUSE_CNT_W-1:0]  cnt_r, nxt_cnt_s;
  logic [EFUSE_ADDR_W-1:0] idx_r, nxt_idx_s;
  logic                    req_q_r;
  logic                    start_s;
  logic                    cap_s;

  logic                    csb_r;
  logic                    strobe_r;
  logic [EFUSE_ADDR_W-1:0] addr_r;
  logic                    wen_r;
  logic [EFUSE_ADDR_W-1:0] waddr_r;
  logic [EFUSE_DATA_W-1:0] wdata_r;
  logic                    done_r;
  logic                    busy_r;

  // A held-high request must not retrigger, so only a fresh edge starts a load.
  assign start_s = (state_r == ST_IDLE) && i_efuse_load_req && !req_q_r && i_efuse_ctrl_reg_en;
  // Read data is taken on the final strobe cycle unless the load is being aborted.
  assign cap_s   = (state_r == ST_STRB) && (cnt_r == CNT_ZERO) && i_efuse_ctrl_reg_en;

  // Next-state, phase counter reload and word index sequencing.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_idx_s   = idx_r;
    if ((state_r != ST_IDLE) && !i_efuse_ctrl_reg_en) begin
      nxt_state_s = ST_IDLE;
      nxt_cnt_s   = CNT_ZERO;
      nxt_idx_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            nxt_state_s = ST_SETUP;
            nxt_cnt_s   = TSU_LD;
            nxt_idx_s   = IDX_ZERO;
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            nxt_state_s = ST_STRB;
            nxt_cnt_s   = STRB_LD;
          end else begin
            nxt_cnt_s = cnt_r - EFUSE_CNT_W'(1);
          end
        end
        ST_STRB: begin
          if (cnt_r == CNT_ZERO) begin
            nxt_state_s = ST_HOLD;
            nxt_cnt_s   = THD_LD;
          end else begin
            nxt_cnt_s = cnt_r - EFUSE_CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_r != CNT_ZERO) begin
            nxt_cnt_s = cnt_r - EFUSE_CNT_W'(1);
          end else if (idx_r == LAST_IDX) begin
            nxt_state_s = ST_DONE;
            nxt_cnt_s   = CNT_ZERO;
          end else begin
            nxt_state_s = ST_SETUP;
            nxt_cnt_s   = TSU_LD;
            nxt_idx_s   = idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_ZERO;
          nxt_idx_s   = IDX_ZERO;
        end
        default: begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_ZERO;
          nxt_idx_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // State, counter, index and request-edge history registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      req_q_r <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      idx_r   <= nxt_idx_s;
      req_q_r <= i_efuse_load_req;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csb_r    <= 1'b1;
      strobe_r <= 1'b0;
      addr_r   <= IDX_ZERO;
      wen_r    <= 1'b0;
      waddr_r  <= IDX_ZERO;
      wdata_r  <= {EFUSE_DATA_W{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      csb_r    <= !st_is_active(nxt_state_s);
      strobe_r <= (nxt_state_s == ST_STRB);
      addr_r   <= st_is_active(nxt_state_s) ? nxt_idx_s : IDX_ZERO;
      wen_r    <= cap_s;
      waddr_r  <= cap_s ? idx_r : waddr_r;
      wdata_r  <= cap_s ? efuse_bus.efuse_rdata : wdata_r;
      done_r   <= (nxt_state_s == ST_DONE);
      busy_r   <= (nxt_state_s != ST_IDLE);
    end
  end

  assign efuse_bus.efuse_csb    = csb_r;
  assign efuse_bus.efuse_strobe = strobe_r;
  assign efuse_bus.efuse_addr   = addr_r;
  assign efuse_bus.reg_wen      = wen_r;
  assign efuse_bus.reg_waddr    = waddr_r;
  assign efuse_bus.reg_wdata    = wdata_r;
  assign o_efuse_load_done      = done_r;
  assign o_efuse_busy           = busy_r;

`ifdef HV_EFUSE_CSUM_EN
  logic csum_acc_en_s;
  logic csum_chk_s;

  // The last word is the checksum itself and is excluded from the XOR.
  assign csum_acc_en_s = wen_r && (waddr_r != LAST_IDX);
  assign csum_chk_s    = (state_r == ST_HOLD) && (nxt_state_s == ST_DONE);

  hv_efuse_csum #(
    .DATA_W (EFUSE_DATA_W)
  ) u_csum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (start_s),
    .i_acc_en   (csum_acc_en_s),
    .i_acc_data (wdata_r),
    .i_chk      (csum_chk_s),
    .i_chk_data (wdata_r),
    .o_err      (o_efuse_csum_err)
  );
`else
  assign o_efuse_csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Self-checking bench for hv_efuse_load_ctrl: randomized efuse contents and
// request timing, checked against a timing/contents model derived from the
// word count and phase lengths.
module tb_hv_efuse_load_ctrl;

  localparam int N    = 8;
  localparam int TSU  = 2;
  localparam int STRB = 4;
  localparam int THD  = 2;
  localparam int PER  = TSU + STRB + THD;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic en;
  logic done;
  logic busy;
  logic csum_err;

  logic [7:0] mem [16];
  int cyc = 0;
  int run_len = 0;

  int wr_cyc[$];
  int wr_addr[$];
  int wr_data[$];
  int done_cyc[$];
  int done_err[$];
  int strb_runs[$];

  int n_checks = 0;
  int n_fail   = 0;

  hv_efuse_load_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  hv_efuse_load_ctrl #(
    .EFUSE_WORD_NUM (N),
    .EFUSE_DATA_W   (8),
    .EFUSE_ADDR_W   (4),
    .TSU_CYC        (TSU),
    .STRB_CYC       (STRB),
    .THD_CYC        (THD)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_efuse_load_req    (req),
    .i_efuse_ctrl_reg_en (en),
    .o_efuse_load_done   (done),
    .o_efuse_busy        (busy),
    .o_efuse_csum_err    (csum_err),
    .efuse_bus           (bus)
  );

  // Efuse macro model: combinational read of the fuse array.
  assign bus.efuse_rdata = mem[bus.efuse_addr];

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log register writes, done pulses and strobe pulse widths.
  always @(negedge clk) begin
    if (bus.reg_wen) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bus.reg_waddr));
      wr_data.push_back(int'(bus.reg_wdata));
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_err.push_back(int'(csum_err));
    end
    if (bus.efuse_strobe) begin
      run_len <= run_len + 1;
    end else begin
      if (run_len != 0) strb_runs.push_back(run_len);
      run_len <= 0;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected checksum flag for the current fuse contents.
  function automatic int exp_err();
`ifdef HV_EFUSE_CSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < N - 1; i++) x = x ^ mem[i];
    return (x != mem[N-1]) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Compare logged activity since the given snapshot against the model.
  task automatic check_load(input string tag, input int wb, input int db, input int sb,
                            input int t0, input int nwr, input int ndone, input bit chk_runs);
    check({tag, "_nwr"}, wr_addr.size() - wb, nwr);
    for (int i = 0; i < nwr && (wb + i) < wr_addr.size(); i++) begin
      check($sformatf("%s_waddr%0d", tag, i), wr_addr[wb+i], i);
      check($sformatf("%s_wdata%0d", tag, i), wr_data[wb+i], int'(mem[i]));
      check($sformatf("%s_wcyc%0d", tag, i), wr_cyc[wb+i] - t0, 1 + i * PER + TSU + STRB);
    end
    check({tag, "_ndone"}, done_cyc.size() - db, ndone);
    if (ndone == 1 && done_cyc.size() > db) begin
      check({tag, "_done_lat"}, done_cyc[db] - t0, 1 + N * PER);
      check({tag, "_csum"}, done_err[db], exp_err());
    end
    if (chk_runs) begin
      check({tag, "_nstrb"}, strb_runs.size() - sb, N);
      for (int i = sb; i < strb_runs.size(); i++)
        check($sformatf("%s_strb_len%0d", tag, i - sb), strb_runs[i], STRB);
    end
  endtask

  // One full load: request high for 'hold' cycles, optional re-edge while busy.
  task automatic run_load(input string tag, input int hold, input bit toggle_busy);
    int wb, db, sb, t0, wait_n;
    wb = wr_addr.size();
    db = done_cyc.size();
    sb = strb_runs.size();
    wait_n = ((hold > 90) ? hold : 90) + 2;
    req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < wait_n; k++) begin
      if (toggle_busy && k == 20) req = 1'b0;
      if (toggle_busy && k == 23) req = 1'b1;
      if (k == hold) req = 1'b0;
      step(1);
    end
    req = 1'b0;
    step(2);
    check_load(tag, wb, db, sb, t0, N, 1, 1'b1);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_csb"}, int'(bus.efuse_csb), 1);
    check({tag, "_strobe"}, int'(bus.efuse_strobe), 0);
    check({tag, "_addr"}, int'(bus.efuse_addr), 0);
    check({tag, "_wen"}, int'(bus.reg_wen), 0);
    check({tag, "_waddr"}, int'(bus.reg_waddr), 0);
    check({tag, "_wdata"}, int'(bus.reg_wdata), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(csum_err), 0);
  endtask

  initial begin
    int wb, db, sb, t0;
    bit found;
    rst_n = 1'b0;
    req   = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    step(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    step(2);

    // Directed load with rdata = 0x10 + addr.
    run_load("basic", 3, 1'b0);

    // Request held 200 cycles: one load only; then a second edge reloads.
    run_load("held", 200, 1'b0);
    run_load("second", 5, 1'b0);

    // Re-edge while busy is ignored.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    run_load("busy_edge", 100, 1'b1);

    // Randomized contents and request durations.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_load($sformatf("rand%0d", r), int'($urandom_range(1, 200)), 1'b0);
    end

    // Request edge coinciding with enable low does not start.
    wb = wr_addr.size();
    en = 1'b0;
    req = 1'b1;
    step(1);
    en = 1'b1;
    step(80);
    check("en_low_nwr", wr_addr.size() - wb, 0);
    check("en_low_busy", int'(busy), 0);
    req = 1'b0;
    step(2);

    // Abort: drop enable during word 3 strobe.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    wb = wr_addr.size();
    db = done_cyc.size();
    sb = strb_runs.size();
    req = 1'b1;
    t0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (bus.efuse_strobe && bus.efuse_addr == 4'd3) found = 1'b1;
      else step(1);
    end
    check("abort_reach_w3", int'(found), 1);
    step(int'($urandom_range(0, STRB - 1)));
    en = 1'b0;
    step(1);
    check("abort_busy", int'(busy), 0);
    check("abort_csb", int'(bus.efuse_csb), 1);
    check("abort_strobe", int'(bus.efuse_strobe), 0);
    step(100);
    check_load("abort", wb, db, sb, t0, 3, 0, 1'b0);
    en = 1'b1;
    req = 1'b0;
    step(2);

    // Reset during word 5 hold.
    wb = wr_addr.size();
    req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (bus.reg_wen && bus.reg_waddr == 4'd5) found = 1'b1;
      else step(1);
    end
    check("rst_reach_w5", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    req = 1'b0;
    step(2);
    rst_n = 1'b1;
    wb = wr_addr.size();
    db = done_cyc.size();
    step(60);
    check("postrst_nwr", wr_addr.size() - wb, 0);
    check("postrst_ndone", done_cyc.size() - db, 0);
    check("postrst_busy", int'(busy), 0);
    run_load("after_rst", 4, 1'b0);

    // Checksum vectors.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    mem[4] = 8'h10; mem[5] = 8'h20; mem[6] = 8'h40; mem[7] = 8'h7F;
    run_load("csum_ok", 5, 1'b0);
    mem[7] = 8'h7E;
    run_load("csum_bad", 5, 1'b0);
    check("csum_hold", int'(csum_err), exp_err());
    req = 1'b1;
    step(2);
    check("csum_clr", int'(csum_err), 0);
    step(90);
    req = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
